full_adder_dataflow: RTL and testbench
======================================

// Module: full_adder_dataflow
// PURPOSE
//  Parameterised ripple-carry adder built from dataflow (continuous-assign) full-adder cells.
//  Default WIDTH=1 is a plain single-bit full adder: sum/carry_out are pure combinational functions of a, b, carry_in.
//  A registered copy of the result (sum_q/cout_q) is provided for synchronous consumers.
//  Used as a leaf arithmetic cell in datapaths and as a teaching/reference adder.
// PARAMETERS
//  WIDTH  1  operand width in bits (>=1); ripple chain of WIDTH full-adder cells
// PORTS
//  clk        input   1      rising-edge clock; used only by the registered outputs
//  rst_n      input   1      asynchronous, active-low reset; clears the registered outputs
//  sum        output  WIDTH  combinational sum bits
//  carry_out  output  1      combinational carry out of MSB cell
//  a          input   WIDTH  operand A
//  b          input   WIDTH  operand B
//  carry_in   input   1      carry into LSB cell
//  sum_q      output  WIDTH  sum registered on clk
//  cout_q     output  1      carry_out registered on clk
//  ovf_q      output  1      signed overflow of the registered result
// BEHAVIOUR
//  - Cell i: s[i] = a[i]^b[i]^c[i]; c[i+1] = (a[i]&b[i]) | (c[i]&(a[i]^b[i])); c[0]=carry_in.
//  - sum = s[WIDTH-1:0]; carry_out = c[WIDTH]. Equivalent to {carry_out,sum} = a+b+carry_in
//    with (WIDTH+1)-bit result; no truncation or saturation.
//  - sum/carry_out: zero latency, purely combinational, independent of clk and rst_n
//    (valid even while rst_n=0). No internal state on this path.
//  - Signed overflow: ovf = c[WIDTH] ^ c[WIDTH-1]; for WIDTH=1 it is c[1]^carry_in.
//  - Registered path: on posedge clk, sum_q<=sum, cout_q<=carry_out, ovf_q<=ovf (1-cycle latency).
//  - rst_n low asynchronously forces sum_q=0, cout_q=0, ovf_q=0 immediately, independent of clk;
//    they hold 0 while rst_n low. First capture happens on the first posedge after rst_n goes high.
//  - Reset asserted mid-operation: registered outputs clear at once; combinational outputs unaffected.
//  - X/Z on any input propagates to the affected outputs; no input sanitising.
//  - No handshake, no enable; a new result is captured every clock.
//  - Boundary: all-ones a and b with carry_in=1 gives sum=all-ones, carry_out=1 (max value 2^(WIDTH+1)-1).
// TESTING
//  - WIDTH=1 exhaustive truth table, 1 time unit per vector, carry_in 0 then 1:
//    (a,b,cin)=000->s0 c0; 100->s1 c0; 010->s1 c0; 110->s0 c1; 001->s1 c0; 101->s0 c1; 011->s0 c1; 111->s1 c1.
//    Outputs must settle in the same time step as the input change (no clock needed).
//  - Reset: rst_n=0 with a=1,b=1,cin=1 -> sum=1,carry_out=1 combinationally while sum_q=0,cout_q=0,ovf_q=0;
//    release rst_n, one posedge -> sum_q=1, cout_q=1.
//  - Registered latency: change inputs 000->110 just after a posedge -> sum_q/cout_q stay 0/0
//    until the next posedge, then read 0/1.
//  - WIDTH=8: a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, carry_out=1, ovf=0; a=8'h7F, b=8'h01 -> sum=8'h80, carry_out=0, ovf=1.
//  - WIDTH=8 random: 1000 vectors checked against {carry_out,sum} == a+b+carry_in and registered copy 1 cycle later.
//  - Async reset mid-run: assert rst_n=0 between clock edges -> registered outputs go 0 without waiting for clk.

Source files
------------

// File: rtl/full_adder_dataflow.sv
// Parameterised ripple-carry adder built from dataflow full-adder cells, with a
// combinational result path and a registered copy (sum_q/cout_q/ovf_q) for synchronous consumers.

module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic prop_s;

  assign prop_s = a ^ b;
  assign s      = prop_s ^ cin;
  assign cout   = (a & b) | (cin & prop_s);

endmodule

module full_adder_dataflow #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic [WIDTH-1:0] sum_q,
  output logic             cout_q,
  output logic             ovf_q
);

  // Signed overflow: carry into the MSB cell disagrees with carry out of it.
  function automatic logic signed_ovf(input logic c_msb_out, input logic c_msb_in);
    return c_msb_out ^ c_msb_in;
  endfunction

  logic [WIDTH:0]   carry_s;
  logic [WIDTH-1:0] sum_s;
  logic             ovf_s;
  logic [WIDTH-1:0] sum_r;
  logic             cout_r;
  logic             ovf_r;

  assign carry_s[0] = carry_in;

  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_cell
      full_adder_cell u_cell (
        .a    (a[i]),
        .b    (b[i]),
        .cin  (carry_s[i]),
        .s    (sum_s[i]),
        .cout (carry_s[i+1])
      );
    end
  endgenerate

  // For WIDTH=1, carry_s[WIDTH-1] is carry_in itself.
  assign ovf_s     = signed_ovf(carry_s[WIDTH], carry_s[WIDTH-1]);
  assign sum       = sum_s;
  assign carry_out = carry_s[WIDTH];

  // Capture the combinational result every clock; async reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_r  <= {WIDTH{1'b0}};
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else begin
      sum_r  <= sum_s;
      cout_r <= carry_s[WIDTH];
      ovf_r  <= ovf_s;
    end
  end

  assign sum_q  = sum_r;
  assign cout_q = cout_r;
  assign ovf_q  = ovf_r;

endmodule

// File: tb/tb_full_adder_dataflow.sv
// Directed and random checks of full_adder_dataflow at WIDTH=1 and WIDTH=8,
// covering combinational paths, registered latency and asynchronous reset.

module tb_full_adder_dataflow;

  typedef struct packed {
    logic a;
    logic b;
    logic cin;
    logic s;
    logic c;
  } vec1_t;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] s;
    logic       c;
    logic       ovf;
  } vec8_t;

  logic       clk;
  logic       rst_n;
  logic [0:0] a1, b1, sum1, sum1_q;
  logic       cin1, cout1, cout1_q, ovf1_q;
  logic [7:0] a8, b8, sum8, sum8_q;
  logic       cin8, cout8, cout8_q, ovf8_q;

  int n_checks;
  int n_fail;

  full_adder_dataflow #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .sum(sum1), .carry_out(cout1),
    .a(a1), .b(b1), .carry_in(cin1),
    .sum_q(sum1_q), .cout_q(cout1_q), .ovf_q(ovf1_q)
  );

  full_adder_dataflow #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .sum(sum8), .carry_out(cout8),
    .a(a8), .b(b8), .carry_in(cin8),
    .sum_q(sum8_q), .cout_q(cout8_q), .ovf_q(ovf8_q)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  vec1_t tv1[8];
  vec8_t tv8[4];

  initial begin
    logic [8:0] exp_r;
    logic       exp_ovf;

    n_checks = 0;
    n_fail   = 0;
    clk   = 1'b0;
    rst_n = 1'b0;
    a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
    a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0;

    tv1[0] = '{a:1'b0, b:1'b0, cin:1'b0, s:1'b0, c:1'b0};
    tv1[1] = '{a:1'b1, b:1'b0, cin:1'b0, s:1'b1, c:1'b0};
    tv1[2] = '{a:1'b0, b:1'b1, cin:1'b0, s:1'b1, c:1'b0};
    tv1[3] = '{a:1'b1, b:1'b1, cin:1'b0, s:1'b0, c:1'b1};
    tv1[4] = '{a:1'b0, b:1'b0, cin:1'b1, s:1'b1, c:1'b0};
    tv1[5] = '{a:1'b1, b:1'b0, cin:1'b1, s:1'b0, c:1'b1};
    tv1[6] = '{a:1'b0, b:1'b1, cin:1'b1, s:1'b0, c:1'b1};
    tv1[7] = '{a:1'b1, b:1'b1, cin:1'b1, s:1'b1, c:1'b1};

    tv8[0] = '{a:8'hFF, b:8'h01, cin:1'b0, s:8'h00, c:1'b1, ovf:1'b0};
    tv8[1] = '{a:8'h7F, b:8'h01, cin:1'b0, s:8'h80, c:1'b0, ovf:1'b1};
    tv8[2] = '{a:8'hFF, b:8'hFF, cin:1'b1, s:8'hFF, c:1'b1, ovf:1'b0};
    tv8[3] = '{a:8'h80, b:8'h80, cin:1'b0, s:8'h00, c:1'b1, ovf:1'b1};

    // Reset state of registered outputs
    #1;
    check("rst_sum1_q", 32'(sum1_q), 32'd0);
    check("rst_cout1_q", 32'(cout1_q), 32'd0);
    check("rst_ovf1_q", 32'(ovf1_q), 32'd0);
    check("rst_sum8_q", 32'(sum8_q), 32'd0);

    // WIDTH=1 truth table, one time unit per vector, no clock needed
    for (int i = 0; i < 8; i++) begin
      a1 = tv1[i].a; b1 = tv1[i].b; cin1 = tv1[i].cin;
      #1;
      check($sformatf("tt%0d_sum", i), 32'(sum1), 32'(tv1[i].s));
      check($sformatf("tt%0d_cout", i), 32'(cout1), 32'(tv1[i].c));
    end

    // Combinational path live during reset while registers hold zero
    a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1;
    #1;
    check("rstc_sum", 32'(sum1), 32'd1);
    check("rstc_cout", 32'(cout1), 32'd1);
    check("rstc_sum_q", 32'(sum1_q), 32'd0);
    check("rstc_cout_q", 32'(cout1_q), 32'd0);
    check("rstc_ovf_q", 32'(ovf1_q), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk) #1;
    check("rel_sum_q", 32'(sum1_q), 32'd1);
    check("rel_cout_q", 32'(cout1_q), 32'd1);
    check("rel_ovf_q", 32'(ovf1_q), 32'd0);

    // One-cycle latency of registered path
    @(negedge clk) begin a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0; end
    @(posedge clk) #1;
    check("lat0_sum_q", 32'(sum1_q), 32'd0);
    check("lat0_cout_q", 32'(cout1_q), 32'd0);
    a1 = 1'b1; b1 = 1'b1;
    #2;
    check("lat1_sum_q", 32'(sum1_q), 32'd0);
    check("lat1_cout_q", 32'(cout1_q), 32'd0);
    @(posedge clk) #1;
    check("lat2_sum_q", 32'(sum1_q), 32'd0);
    check("lat2_cout_q", 32'(cout1_q), 32'd1);
    check("lat2_ovf_q", 32'(ovf1_q), 32'd1);

    // Async reset between edges clears registers immediately
    a1 = 1'b1; b1 = 1'b0; cin1 = 1'b0;
    a8 = 8'h7F; b8 = 8'h01; cin8 = 1'b0;
    @(posedge clk) #1;
    check("pre_sum1_q", 32'(sum1_q), 32'd1);
    check("pre_sum8_q", 32'(sum8_q), 32'h80);
    #2 rst_n = 1'b0;
    #1;
    check("async_sum1_q", 32'(sum1_q), 32'd0);
    check("async_sum8_q", 32'(sum8_q), 32'd0);
    check("async_ovf8_q", 32'(ovf8_q), 32'd0);
    check("async_sum1_comb", 32'(sum1), 32'd1);
    check("async_sum8_comb", 32'(sum8), 32'h80);
    @(negedge clk) rst_n = 1'b1;

    // WIDTH=8 directed boundaries
    for (int i = 0; i < 4; i++) begin
      @(negedge clk) begin a8 = tv8[i].a; b8 = tv8[i].b; cin8 = tv8[i].cin; end
      #1;
      check($sformatf("w8d%0d_sum", i), 32'(sum8), 32'(tv8[i].s));
      check($sformatf("w8d%0d_cout", i), 32'(cout8), 32'(tv8[i].c));
      @(posedge clk) #1;
      check($sformatf("w8d%0d_sum_q", i), 32'(sum8_q), 32'(tv8[i].s));
      check($sformatf("w8d%0d_cout_q", i), 32'(cout8_q), 32'(tv8[i].c));
      check($sformatf("w8d%0d_ovf_q", i), 32'(ovf8_q), 32'(tv8[i].ovf));
    end

    // WIDTH=8 random against arithmetic model
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk) begin
        a8   = 8'($urandom_range(255, 0));
        b8   = 8'($urandom_range(255, 0));
        cin8 = 1'($urandom_range(1, 0));
      end
      exp_r   = {1'b0, a8} + {1'b0, b8} + {8'h00, cin8};
      exp_ovf = (a8[7] == b8[7]) && (exp_r[7] != a8[7]);
      #1;
      check("rnd_comb", 32'({cout8, sum8}), 32'(exp_r));
      @(posedge clk) #1;
      check("rnd_reg", 32'({ovf8_q, cout8_q, sum8_q}), 32'({exp_ovf, exp_r}));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
